// File: rtl/inst_buffer.sv
// rtl/inst_buffer.sv - circular instruction buffer between predecode and decode
module inst_buffer #(
  parameter int BLOCK_INST_SIZE = 8,
  parameter int FETCH_WIDTH     = 4,
  parameter int DEPTH           = 32,
  parameter int FSQ_WIDTH       = 5
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [BLOCK_INST_SIZE-1:0]          in_en,
  input  logic [$clog2(BLOCK_INST_SIZE):0]    in_num,
  input  logic [BLOCK_INST_SIZE-1:0][31:0]    in_inst,
  input  logic [FSQ_WIDTH-1:0]                in_fsqIdx,
  input  logic                                flush,
  input  logic                                stall,
  output logic                                ibuf_full,
  output logic [FETCH_WIDTH-1:0]              out_en,
  output logic [FETCH_WIDTH-1:0][31:0]        out_inst,
  output logic [FETCH_WIDTH-1:0][FSQ_WIDTH-1:0] out_fsqIdx
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]          inst_mem [DEPTH];
  logic [FSQ_WIDTH-1:0] fsq_mem  [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic          push_ok;
  logic [CW-1:0] push_num;
  logic [CW-1:0] pop_num;

  // Free-space check and lane valids depend only on registered state, so
  // nothing on in_* reaches out_* within a cycle.
  always_comb begin
    ibuf_full = (32'(DEPTH) - 32'(count_q)) < 32'(BLOCK_INST_SIZE);
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      out_en[i]     = 32'(i) < 32'(count_q);
      out_inst[i]   = inst_mem[head_q + PW'(i)];
      out_fsqIdx[i] = fsq_mem[head_q + PW'(i)];
    end
  end

  // Push/pop amounts and next pointer state; flush clears everything.
  always_comb begin
    push_ok  = (|in_en) && !ibuf_full && !flush;
    push_num = push_ok ? CW'(in_num) : '0;
    if (stall || flush)
      pop_num = '0;
    else if (32'(count_q) >= 32'(FETCH_WIDTH))
      pop_num = CW'(FETCH_WIDTH);
    else
      pop_num = count_q;
    head_d  = head_q + PW'(pop_num);
    tail_d  = tail_q + PW'(push_num);
    count_d = count_q + push_num - pop_num;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // Pointer and occupancy registers; reset dominates all other activity.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage: write the valid prefix of the push starting at tail.
  // A push is only accepted with at least BLOCK_INST_SIZE free slots, so
  // live entries are never overwritten.
  always_ff @(posedge clk) begin
    if (push_ok && !rst) begin
      for (int i = 0; i < BLOCK_INST_SIZE; i++) begin
        if (32'(i) < 32'(in_num)) begin
          inst_mem[tail_q + PW'(i)] <= in_inst[i];
          fsq_mem[tail_q + PW'(i)]  <= in_fsqIdx;
        end
      end
    end
  end

endmodule

// File: tb/tb_inst_buffer.sv
// tb/tb_inst_buffer.sv - randomized and directed self-checking bench for inst_buffer
module tb_inst_buffer;

  localparam int BIS   = 8;
  localparam int FW    = 4;
  localparam int DEPTH = 32;
  localparam int FSQ   = 5;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [BIS-1:0]         in_en;
  logic [$clog2(BIS):0]   in_num;
  logic [BIS-1:0][31:0]   in_inst;
  logic [FSQ-1:0]         in_fsqIdx;
  logic                   flush;
  logic                   stall;
  logic                   ibuf_full;
  logic [FW-1:0]          out_en;
  logic [FW-1:0][31:0]    out_inst;
  logic [FW-1:0][FSQ-1:0] out_fsqIdx;

  int vectors     = 0;
  int miscompares = 0;

  // Reference contents, oldest first: {inst, fsqIdx}
  logic [31+FSQ:0] mq[$];

  inst_buffer #(
    .BLOCK_INST_SIZE(BIS),
    .FETCH_WIDTH    (FW),
    .DEPTH          (DEPTH),
    .FSQ_WIDTH      (FSQ)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_en     (in_en),
    .in_num    (in_num),
    .in_inst   (in_inst),
    .in_fsqIdx (in_fsqIdx),
    .flush     (flush),
    .stall     (stall),
    .ibuf_full (ibuf_full),
    .out_en    (out_en),
    .out_inst  (out_inst),
    .out_fsqIdx(out_fsqIdx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input int n, input logic st, input logic fl, input logic rs,
                        input logic [31:0] base, input logic [FSQ-1:0] f);
    in_num = ($clog2(BIS)+1)'(n);
    in_en  = BIS'((1 << n) - 1);
    for (int i = 0; i < BIS; i++) in_inst[i] = (i < n) ? base + 32'(i) : $urandom;
    in_fsqIdx = f;
    stall = st;
    flush = fl;
    rst   = rs;
  endtask

  // Behavioural update: pops come from the old front, pushes append at the back.
  task automatic model_update();
    int pops;
    if (rst || flush) begin
      mq.delete();
    end else begin
      pops = stall ? 0 : ((mq.size() < FW) ? mq.size() : FW);
      if ((in_en != 0) && ((DEPTH - mq.size()) >= BIS))
        for (int i = 0; i < int'(in_num); i++) mq.push_back({in_inst[i], in_fsqIdx});
      for (int i = 0; i < pops; i++) void'(mq.pop_front());
    end
  endtask

  task automatic model_check();
    logic [31+FSQ:0] e;
    chk("ibuf_full", ibuf_full, (DEPTH - mq.size()) < BIS);
    chk("occupancy", mq.size() <= DEPTH, 1);
    for (int i = 0; i < FW; i++) begin
      chk($sformatf("out_en[%0d]", i), out_en[i], i < mq.size());
      if (i < mq.size()) begin
        e = mq[i];
        chk($sformatf("out_inst[%0d]", i), out_inst[i], e[31+FSQ:FSQ]);
        chk($sformatf("out_fsqIdx[%0d]", i), out_fsqIdx[i], e[FSQ-1:0]);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    model_check();
  endtask

  initial begin
    int pct;
    logic [31:0] exp_head;
    @(negedge clk);
    set_in(0, 0, 0, 1, 0, 0);
    step();
    step();
    set_in(0, 0, 0, 0, 0, 0);
    chk("reset_out_en", out_en, 4'b0000);
    chk("reset_full", ibuf_full, 1'b0);

    // Three-instruction push visible one cycle later, then drained
    set_in(3, 0, 0, 0, 32'hA, 5'd5);
    step();
    chk("p3_out_en", out_en, 4'b0111);
    chk("p3_inst0", out_inst[0], 32'hA);
    chk("p3_inst1", out_inst[1], 32'hB);
    chk("p3_inst2", out_inst[2], 32'hC);
    chk("p3_fsq0", out_fsqIdx[0], 5'd5);
    chk("p3_fsq2", out_fsqIdx[2], 5'd5);
    set_in(0, 0, 0, 0, 0, 0);
    step();
    chk("p3_drained", out_en, 4'b0000);

    // Fill under stall: full from 32, fifth push dropped
    for (int k = 0; k < 5; k++) begin
      set_in(8, 1, 0, 0, 32'h100 * (k + 1), FSQ'(k));
      step();
      chk($sformatf("fill_full_%0d", k), ibuf_full, k >= 3);
    end
    chk("fill_out_en", out_en, 4'b1111);
    chk("fill_head", out_inst[0], 32'h100);
    for (int k = 0; k < 8; k++) begin
      set_in(0, 0, 0, 0, 0, 0);
      step();
      chk($sformatf("drain_full_%0d", k), ibuf_full, k == 0);
      if (k < 7) begin
        exp_head = 32'h100 * (((4 * (k + 1)) / 8) + 1) + 32'((4 * (k + 1)) % 8);
        chk($sformatf("drain_head_%0d", k), out_inst[0], exp_head);
      end
    end
    chk("drain_empty", out_en, 4'b0000);

    // Two entries drain in one pop
    set_in(2, 1, 0, 0, 32'h200, 5'd2);
    step();
    set_in(0, 0, 0, 0, 0, 0);
    chk("two_out_en", out_en, 4'b0011);
    step();
    chk("two_empty", out_en, 4'b0000);

    // Flush at count 10 overrides a same-cycle push
    set_in(8, 1, 0, 0, 32'h300, 5'd3);
    step();
    set_in(2, 1, 0, 0, 32'h310, 5'd3);
    step();
    set_in(8, 0, 1, 0, 32'h320, 5'd4);
    step();
    chk("flush_out_en", out_en, 4'b0000);
    chk("flush_full", ibuf_full, 1'b0);
    set_in(0, 0, 0, 0, 0, 0);
    step();
    chk("flush_discard", out_en, 4'b0000);

    // Reset during a push at count 12
    set_in(8, 1, 0, 0, 32'h400, 5'd6);
    step();
    set_in(4, 1, 0, 0, 32'h410, 5'd6);
    step();
    set_in(8, 0, 0, 1, 32'h420, 5'd7);
    step();
    chk("rst_out_en", out_en, 4'b0000);
    chk("rst_full", ibuf_full, 1'b0);

    // Randomized traffic, varying stall pressure to exercise full and wrap
    pct = 20;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) pct = (c / 200) % 3 == 0 ? 20 : ((c / 200) % 3 == 1 ? 60 : 90);
      set_in($urandom_range(0, BIS), $urandom_range(0, 99) < pct,
             $urandom_range(0, 49) == 0, $urandom_range(0, 149) == 0,
             $urandom, FSQ'($urandom));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
